mem_access_unit: RTL

- Initiator-side load/store controller between the CPU datapath and the word-addressed data memory.
- Accepts byte-addressed load/store requests of byte, halfword or word size and converts them into word-wide memory read/write cycles.
- Sub-word stores use read-modify-write; sub-word loads are extracted and sign- or zero-extended.
- Detects misaligned and out-of-range accesses and reports them without touching memory.

---
 rtl/mem_pkg.sv | 57 +++++
 rtl/mem_access_unit_lane_align.sv | 17 +
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the load/store unit.
// Lanes are little-endian: byte n lives in bits [8n+7:8n].
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  addr_lo,
        input logic [1:0]  size,
        input logic        sign_ext
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{sign_ext & b[7]}}, b};
            SZ_HALF: r = {{16{sign_ext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  addr_lo,
        input logic [1:0]  size
    );
        logic [31:0] r;
        r = word;
        case (size)
            SZ_BYTE: r[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (addr_lo[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane extract (loads) and merge (sub-word stores).
module lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    assign load_data  = lane_extract(word, addr_lo, size, sign_ext);
    assign merge_data = lane_merge(word, wdata, addr_lo, size);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store controller: byte-addressed requests to word-wide memory cycles,
// with read-modify-write for sub-word stores and up-front access checking.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int RD_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writeData,
    input  logic [31:0] mem_readData
);

    localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
    localparam logic [1:0]  LAST_CNT = 2'(RD_LATENCY - 1);

    state_t      state_r;
    logic        we_r;
    logic [1:0]  size_r;
    logic        sign_ext_r;
    logic [1:0]  addr_lo_r;
    logic [31:0] wdata_r;
    logic [1:0]  cnt_r;

    logic        size_err_s;
    logic        range_err_s;
    logic        req_err_s;
    logic [31:0] load_s;
    logic [31:0] merge_s;

    // Alignment and size legality of the incoming request
    always_comb begin
        size_err_s = 1'b0;
        case (size)
            SZ_BYTE: size_err_s = 1'b0;
            SZ_HALF: size_err_s = addr[0];
            SZ_WORD: size_err_s = (addr[1:0] != 2'b00);
            default: size_err_s = 1'b1;
        endcase
    end

    assign range_err_s = (addr[31:2] >= DEPTH_W);
    assign req_err_s   = size_err_s | range_err_s;

    lane_align u_lane_align (
        .word       (mem_readData),
        .wdata      (wdata_r),
        .addr_lo    (addr_lo_r),
        .size       (size_r),
        .sign_ext   (sign_ext_r),
        .load_data  (load_s),
        .merge_data (merge_s)
    );

    // Transaction FSM with all outputs registered
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            we_r          <= 1'b0;
            size_r        <= 2'b00;
            sign_ext_r    <= 1'b0;
            addr_lo_r     <= 2'b00;
            wdata_r       <= 32'h0000_0000;
            cnt_r         <= 2'b00;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            rdata         <= 32'h0000_0000;
            mem_address   <= 32'h0000_0000;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_writeData <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (req) begin
                        we_r        <= we;
                        size_r      <= size;
                        sign_ext_r  <= sign_ext;
                        addr_lo_r   <= addr[1:0];
                        wdata_r     <= wdata;
                        cnt_r       <= 2'b00;
                        mem_address <= {2'b00, addr[31:2]};
                        if (req_err_s) begin
                            // Rejected requests complete at once and never strobe memory
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                            err     <= 1'b1;
                            busy    <= 1'b0;
                        end else if (we && (size == SZ_WORD)) begin
                            state_r       <= ST_WRITE;
                            busy          <= 1'b1;
                            err           <= 1'b0;
                            mem_write     <= 1'b1;
                            mem_writeData <= wdata;
                        end else begin
                            state_r  <= ST_RD_WAIT;
                            busy     <= 1'b1;
                            err      <= 1'b0;
                            mem_read <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt_r == LAST_CNT) begin
                        mem_read <= 1'b0;
                        if (we_r) begin
                            state_r       <= ST_WRITE;
                            mem_write     <= 1'b1;
                            mem_writeData <= merge_s;
                        end else begin
                            state_r <= ST_DONE;
                            rdata   <= load_s;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + 2'd1;
                    end
                end
                ST_WRITE: begin
                    mem_write <= 1'b0;
                    state_r   <= ST_DONE;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
